// File: rtl/sample_ctrl_pkg.sv
// Shared types and default constants for the sample window controller.
// Optional feature macro: SAMPLE_WINDOW_TIMEOUT_EN (adds the ERR state).
package sample_ctrl_pkg;

  localparam int unsigned DEF_NUM_CNT_BITS   = 10;
  localparam int unsigned DEF_WINDOW_LEN     = 1000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;
  localparam int unsigned WIN_CNT_W          = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3
`ifdef SAMPLE_WINDOW_TIMEOUT_EN
    ,
    S_ERR  = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/flex_counter.sv
// Clearable up-counter with programmable rollover value.
// Ports: clk, n_rst (async active-low), clear (sync, highest priority),
//        count_enable, rollover_val; count_out, rollover_flag (registered,
//        high while count_out == rollover_val).
module flex_counter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_next;
  logic                    flag_next;

  // Next count: clear wins, wrap to 1 after reaching rollover_val.
  always_comb begin
    count_next = count_out;
    if (clear) begin
      count_next = '0;
    end else if (count_enable) begin
      if (count_out == rollover_val) count_next = NUM_CNT_BITS'(1);
      else                           count_next = count_out + NUM_CNT_BITS'(1);
    end
    flag_next = !clear && (count_next == rollover_val);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count_out     <= count_next;
      rollover_flag <= flag_next;
    end
  end

endmodule

// File: rtl/sample_window_ctrl.sv
// Sample window controller: counts WINDOW_LEN accepted samples per window,
// runs num_windows windows (0 = continuous) and flags dropped samples.
// Ports: clk, n_rst (async active-low), start, stop, sample_valid,
//        num_windows[7:0]; busy, window_done, win_count[7:0], overrun,
//        timeout_err (all registered).
// Macro SAMPLE_WINDOW_TIMEOUT_EN: adds an idle-gap counter and ERR state;
// without it timeout_err is tied to 0.
module sample_window_ctrl
  import sample_ctrl_pkg::*;
#(
  parameter int unsigned              NUM_CNT_BITS   = DEF_NUM_CNT_BITS,
  parameter logic [NUM_CNT_BITS-1:0]  WINDOW_LEN     = NUM_CNT_BITS'(DEF_WINDOW_LEN),
  parameter int unsigned              TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 sample_valid,
  input  logic [WIN_CNT_W-1:0] num_windows,
  output logic                 busy,
  output logic                 window_done,
  output logic [WIN_CNT_W-1:0] win_count,
  output logic                 overrun,
  output logic                 timeout_err
);

  state_t                  state, state_next;
  logic [WIN_CNT_W-1:0]    nw_q, nw_next, win_next;
  logic                    ovr_next;
  logic                    clear, count_enable, rollover_flag;
  logic [NUM_CNT_BITS-1:0] unused_count;

  // Counter controls decoded straight from state; a full window stops counting.
  assign clear        = (state == S_CLR) || (state == S_DONE);
  assign count_enable = (state == S_RUN) && sample_valid && !rollover_flag;

  flex_counter #(.NUM_CNT_BITS(NUM_CNT_BITS)) u_sample_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (count_enable),
    .rollover_val (WINDOW_LEN),
    .count_out    (unused_count),
    .rollover_flag(rollover_flag)
  );

`ifdef SAMPLE_WINDOW_TIMEOUT_EN
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [GAP_W-1:0] gap_q;
  logic             timeout_hit;
  logic             to_next;

  // Consecutive RUN cycles without a sample.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                            gap_q <= '0;
    else if (state != S_RUN || sample_valid) gap_q <= '0;
    else                                   gap_q <= gap_q + GAP_W'(1);
  end

  assign timeout_hit = (state == S_RUN) && !sample_valid &&
                       (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_err        = 1'b0;
`endif

  // Next-state and next flag values; stop overrides everything outside IDLE.
  always_comb begin
    state_next = state;
    nw_next    = nw_q;
    win_next   = win_count;
    ovr_next   = overrun;
`ifdef SAMPLE_WINDOW_TIMEOUT_EN
    to_next    = timeout_err;
`endif
    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          state_next = S_CLR;
          nw_next    = num_windows;
          win_next   = '0;
          ovr_next   = 1'b0;
`ifdef SAMPLE_WINDOW_TIMEOUT_EN
          to_next    = 1'b0;
`endif
        end
      end
      S_CLR: begin
        if (sample_valid) ovr_next = 1'b1;
        state_next = S_RUN;
      end
      S_RUN: begin
        if (rollover_flag) begin
          if (sample_valid) ovr_next = 1'b1;
          state_next = S_DONE;
`ifdef SAMPLE_WINDOW_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_next = S_ERR;
          to_next    = 1'b1;
`endif
        end
      end
      S_DONE: begin
        if (sample_valid) ovr_next = 1'b1;
        win_next = win_count + WIN_CNT_W'(1);
        if (nw_q != '0 && win_next == nw_q) state_next = S_IDLE;
        else                                state_next = S_RUN;
      end
`ifdef SAMPLE_WINDOW_TIMEOUT_EN
      S_ERR: begin
        if (start) begin
          state_next = S_CLR;
          nw_next    = num_windows;
          win_next   = '0;
          ovr_next   = 1'b0;
          to_next    = 1'b0;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
    if (stop && state != S_IDLE) begin
      state_next = S_IDLE;
      nw_next    = nw_q;
      win_next   = win_count;
      ovr_next   = overrun;
`ifdef SAMPLE_WINDOW_TIMEOUT_EN
      to_next    = timeout_err;
`endif
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= S_IDLE;
      nw_q        <= '0;
      win_count   <= '0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
      window_done <= 1'b0;
    end else begin
      state       <= state_next;
      nw_q        <= nw_next;
      win_count   <= win_next;
      overrun     <= ovr_next;
      busy        <= (state_next == S_CLR) || (state_next == S_RUN) ||
                     (state_next == S_DONE);
      window_done <= (state_next == S_DONE);
    end
  end

`ifdef SAMPLE_WINDOW_TIMEOUT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) timeout_err <= 1'b0;
    else        timeout_err <= to_next;
  end
`endif

endmodule
